spike_rate_decoder: RTL

//   Receiving end of the lif spike output. It turns the 1-bit spike train back into a

---
 rtl/snn_pkg.sv | 9 +
 rtl/sat_counter.sv | 28 ++
 rtl/spike_rate_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared SNN types and widths used by the lif neuron, current sources and rate decoder.
package snn_pkg;

    typedef enum logic {IDLE, COUNT} dec_state_t;

    localparam int SNN_CNT_W = 8;
    localparam int SNN_ISI_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] q_q;

    assign q      = q_q;
    assign at_max = &q_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (inc && !at_max) begin
            q_q <= q_q + 1'b1;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts a lif spike train into a saturating spike count per back-to-back WINDOW-cycle window.
// Define SPIKE_ISI_EN to add the isi_min port (minimum inter-spike interval per window).
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int CNT_W  = SNN_CNT_W
`ifdef SPIKE_ISI_EN
    ,
    parameter int ISI_W  = SNN_ISI_W
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spike,
    input  logic             enable,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun
`ifdef SPIKE_ISI_EN
    ,
    output logic [ISI_W-1:0] isi_min
`endif
);

    localparam int                WC_W   = $clog2(WINDOW);
    localparam logic [WC_W-1:0]   W_LAST = WC_W'(WINDOW - 1);

    dec_state_t        state_q;
    logic [WC_W-1:0]   wcnt_q;
    logic [CNT_W-1:0]  rate_q;
    logic              rate_valid_q;
    logic              overrun_q;

    logic              start;
    logic              counted;
    logic              close;
    logic [CNT_W-1:0]  scnt;
    logic              scnt_max;
    logic [CNT_W-1:0]  rate_d;

    assign start   = (state_q == IDLE) && enable;
    assign counted = (state_q == COUNT) && enable;
    assign close   = counted && (wcnt_q == W_LAST);

    sat_counter #(.W(CNT_W)) u_scnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start || close),
        .inc     (counted && spike),
        .q       (scnt),
        .at_max  (scnt_max)
    );

    // The closing cycle's own spike still belongs to the window being reported.
    assign rate_d = (spike && !scnt_max) ? scnt + 1'b1 : scnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= COUNT;
                        wcnt_q  <= '0;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else begin
                        wcnt_q <= close ? '0 : wcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (close) begin
                rate_q       <= rate_d;
                rate_valid_q <= 1'b1;
                if (rate_valid_q && !rate_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (rate_valid_q && rate_ready) begin
                rate_valid_q <= 1'b0;
            end
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign overrun    = overrun_q;

`ifdef SPIKE_ISI_EN
    localparam logic [ISI_W-1:0] ISI_ONES = {ISI_W{1'b1}};

    logic [ISI_W-1:0] isi_cnt;
    logic             isi_cnt_max;
    logic [ISI_W-1:0] isi_cand;
    logic [ISI_W-1:0] isi_best;
    logic             isi_hit;
    logic             isi_seen_q;
    logic [ISI_W-1:0] isi_run_q;
    logic [ISI_W-1:0] isi_min_q;

    // Holds the number of counted cycles strictly between the previous spike and now.
    sat_counter #(.W(ISI_W)) u_isi (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start || close || (counted && spike)),
        .inc     (counted && !spike),
        .q       (isi_cnt),
        .at_max  (isi_cnt_max)
    );

    assign isi_cand = isi_cnt_max ? isi_cnt : isi_cnt + 1'b1;
    assign isi_hit  = counted && spike && isi_seen_q;
    assign isi_best = (isi_hit && (isi_cand < isi_run_q)) ? isi_cand : isi_run_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            isi_seen_q <= 1'b0;
            isi_run_q  <= ISI_ONES;
            isi_min_q  <= ISI_ONES;
        end else if (start || close) begin
            isi_seen_q <= 1'b0;
            isi_run_q  <= ISI_ONES;
            if (close) begin
                isi_min_q <= isi_best;
            end
        end else if (counted && spike) begin
            isi_seen_q <= 1'b1;
            isi_run_q  <= isi_best;
        end
    end

    assign isi_min = isi_min_q;
`endif

endmodule
